// File: rtl/lamp_fpu_cmp_frontend_pkg.sv
// Shared types and widths for the lampFPU compare front-end.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package lamp_fpu_cmp_frontend_pkg;

  localparam int LAMP_FLOAT_DW       = 16;
  localparam int LAMP_FLOAT_S_DW     = 1;
  localparam int LAMP_FLOAT_E_DW     = 8;
  localparam int LAMP_FLOAT_F_DW     = 7;
  localparam int LAMP_FLOAT_QNAN_BIT = 6;

  typedef enum logic [1:0] {
    CMP_EQ  = 2'b00,
    CMP_LT  = 2'b01,
    CMP_LE  = 2'b10,
    CMP_ILL = 2'b11
  } cmpOp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } cmpFeState_t;

  // One operand after unpacking and classification (denormals already flushed).
  typedef struct packed {
    logic [LAMP_FLOAT_S_DW-1:0] sign;
    logic [LAMP_FLOAT_E_DW-1:0] exp;
    logic [LAMP_FLOAT_F_DW-1:0] fract;
    logic                       is_zer;
    logic                       is_snan;
    logic                       is_qnan;
  } fp_cls_t;

  // Comparator command vector, ordered {le, lt, eq}. The illegal opcode
  // never reaches the comparator, so it decodes to no command at all.
  function automatic logic [2:0] op_to_do(input cmpOp_t op);
    logic [2:0] v;
    v = 3'b000;
    case (op)
      CMP_EQ:  v = 3'b001;
      CMP_LT:  v = 3'b010;
      CMP_LE:  v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/lamp_fpu_cmp_frontend_if.sv
// Bundle of the request, response and comparator-side signals of the front-end.
// Latency: n/a (wiring only).
// Backpressure: req_valid_i/req_ready_o and rsp_valid_o/rsp_ready_i handshakes.
// Modports: master = core dispatch plus comparator environment, slave = front-end.
interface lamp_fpu_cmp_frontend_if;
  import lamp_fpu_cmp_frontend_pkg::*;

  // request channel
  logic                       req_valid_i;
  logic                       req_ready_o;
  logic [1:0]                 req_op_i;
  logic [LAMP_FLOAT_DW-1:0]   req_opA_i;
  logic [LAMP_FLOAT_DW-1:0]   req_opB_i;

  // comparator command and operand fields
  logic                       doEq_o;
  logic                       doLt_o;
  logic                       doLe_o;
  logic                       opASign_o;
  logic                       opBSign_o;
  logic [LAMP_FLOAT_E_DW-1:0] opAExp_o;
  logic [LAMP_FLOAT_E_DW-1:0] opBExp_o;
  logic [LAMP_FLOAT_F_DW-1:0] opAFract_o;
  logic [LAMP_FLOAT_F_DW-1:0] opBFract_o;
  logic                       isAZer_o;
  logic                       isASNaN_o;
  logic                       isAQNaN_o;
  logic                       isBZer_o;
  logic                       isBSNaN_o;
  logic                       isBQNaN_o;

  // comparator result
  logic                       cmp_i;
  logic                       isCmpValid_i;
  logic                       isCmpInvalid_i;

  // response channel
  logic                       rsp_valid_o;
  logic                       rsp_ready_i;
  logic                       rsp_cmp_o;
  logic                       rsp_invalid_o;

  modport master (
    output req_valid_i, req_op_i, req_opA_i, req_opB_i, rsp_ready_i,
           cmp_i, isCmpValid_i, isCmpInvalid_i,
    input  req_ready_o, doEq_o, doLt_o, doLe_o,
           opASign_o, opBSign_o, opAExp_o, opBExp_o, opAFract_o, opBFract_o,
           isAZer_o, isASNaN_o, isAQNaN_o, isBZer_o, isBSNaN_o, isBQNaN_o,
           rsp_valid_o, rsp_cmp_o, rsp_invalid_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_opA_i, req_opB_i, rsp_ready_i,
           cmp_i, isCmpValid_i, isCmpInvalid_i,
    output req_ready_o, doEq_o, doLt_o, doLe_o,
           opASign_o, opBSign_o, opAExp_o, opBExp_o, opAFract_o, opBFract_o,
           isAZer_o, isASNaN_o, isAQNaN_o, isBZer_o, isBSNaN_o, isBQNaN_o,
           rsp_valid_o, rsp_cmp_o, rsp_invalid_o
  );

endinterface

// File: rtl/lamp_fpu_cmp_frontend_classify.sv
// Unpacks one bfloat16 operand and flags zero/SNaN/QNaN, flushing denormals to signed zero.
// Latency: combinational.
// Backpressure: none.
// Ports: opnd (packed bfloat16 in), cls (classified fields out).
module lamp_fpu_classify
  import lamp_fpu_cmp_frontend_pkg::*;
(
  input  logic [LAMP_FLOAT_DW-1:0] opnd,
  output fp_cls_t                  cls
);

  logic [LAMP_FLOAT_S_DW-1:0] s;
  logic [LAMP_FLOAT_E_DW-1:0] e;
  logic [LAMP_FLOAT_F_DW-1:0] f;

  assign s = opnd[LAMP_FLOAT_DW-1 -: LAMP_FLOAT_S_DW];
  assign e = opnd[LAMP_FLOAT_F_DW +: LAMP_FLOAT_E_DW];
  assign f = opnd[LAMP_FLOAT_F_DW-1:0];

  always_comb begin
    cls      = '0;
    cls.sign = s;
    if (e == '0) begin
      // true zero and denormal both leave as a signed zero
      cls.is_zer = 1'b1;
    end else begin
      cls.exp   = e;
      cls.fract = f;
      // all-ones exponent with zero fraction is infinity: no flag
      if (e == '1 && f != '0) begin
        cls.is_qnan = f[LAMP_FLOAT_QNAN_BIT];
        cls.is_snan = ~f[LAMP_FLOAT_QNAN_BIT];
      end
    end
  end

endmodule

// File: rtl/lamp_fpu_cmp_frontend.sv
// Request-side driver for lampFPU_cmp: accept, classify, pulse one do*, capture result, respond.
// Latency: response valid 2 cycles after accept (1 cycle for the illegal opcode).
// Backpressure: response held until rsp_ready_i; req_ready_o only in IDLE or on a completing response.
// Ports: clk, rst (async, active-low), bus (slave side of lamp_fpu_cmp_frontend_if).
module lamp_fpu_cmp_frontend
  import lamp_fpu_cmp_frontend_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  lamp_fpu_cmp_frontend_if.slave  bus
);

  cmpFeState_t state;
  cmpOp_t      op_q;
  cmpOp_t      req_op;
  fp_cls_t     a_cls;
  fp_cls_t     b_cls;
  fp_cls_t     a_q;
  fp_cls_t     b_q;
  logic        rsp_valid_q;
  logic        rsp_cmp_q;
  logic        rsp_inv_q;
  logic        req_ready;
  logic        accept;
  logic [2:0]  do_vec;

  lamp_fpu_classify u_cls_a (.opnd(bus.req_opA_i), .cls(a_cls));
  lamp_fpu_classify u_cls_b (.opnd(bus.req_opB_i), .cls(b_cls));

  assign req_op = cmpOp_t'(bus.req_op_i);

  // A finishing response frees the slot in the same cycle, so a new request
  // can be taken while the old one is being handed off.
  assign req_ready = (state == IDLE) || (state == RESP && bus.rsp_ready_i);
  assign accept    = bus.req_valid_i && req_ready;

  // Decoded from registered state and opcode only, so the pulse lasts exactly
  // the ISSUE cycle and drops the moment reset forces IDLE.
  assign do_vec = (state == ISSUE) ? op_to_do(op_q) : 3'b000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      op_q        <= CMP_EQ;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_cmp_q   <= 1'b0;
      rsp_inv_q   <= 1'b0;
    end else if (accept) begin
      op_q <= req_op;
      a_q  <= a_cls;
      b_q  <= b_cls;
      if (req_op == CMP_ILL) begin
        // answered locally, the comparator is never involved
        state       <= RESP;
        rsp_valid_q <= 1'b1;
        rsp_cmp_q   <= 1'b0;
        rsp_inv_q   <= 1'b1;
      end else begin
        state       <= ISSUE;
        rsp_valid_q <= 1'b0;
      end
    end else begin
      case (state)
        ISSUE: state <= WAIT;
        WAIT: begin
          if (bus.isCmpValid_i) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_cmp_q   <= bus.cmp_i;
            rsp_inv_q   <= bus.isCmpInvalid_i;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state <= state;
      endcase
    end
  end

  assign bus.req_ready_o   = req_ready;
  assign bus.doEq_o        = do_vec[0];
  assign bus.doLt_o        = do_vec[1];
  assign bus.doLe_o        = do_vec[2];
  assign bus.opASign_o     = a_q.sign[0];
  assign bus.opBSign_o     = b_q.sign[0];
  assign bus.opAExp_o      = a_q.exp;
  assign bus.opBExp_o      = b_q.exp;
  assign bus.opAFract_o    = a_q.fract;
  assign bus.opBFract_o    = b_q.fract;
  assign bus.isAZer_o      = a_q.is_zer;
  assign bus.isASNaN_o     = a_q.is_snan;
  assign bus.isAQNaN_o     = a_q.is_qnan;
  assign bus.isBZer_o      = b_q.is_zer;
  assign bus.isBSNaN_o     = b_q.is_snan;
  assign bus.isBQNaN_o     = b_q.is_qnan;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_cmp_o     = rsp_cmp_q;
  assign bus.rsp_invalid_o = rsp_inv_q;

endmodule

// File: tb/tb_lamp_fpu_cmp_frontend.sv
// Directed bench for lamp_fpu_cmp_frontend with a behavioural comparator as consumer.
// Latency: n/a.
// Backpressure: driven by the directed steps through rsp_ready_i.
module tb_lamp_fpu_cmp_frontend;
  import lamp_fpu_cmp_frontend_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lamp_fpu_cmp_frontend_if bus();

  lamp_fpu_cmp_frontend dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int n_eq = 0, n_lt = 0, n_le = 0;
  logic [1:0] sb[$];
  logic [1:0] last_exp;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  fl;   // {AZer, ASNaN, AQNaN, BZer, BSNaN, BQNaN}
    logic        ec;
    logic        ei;
  } vec_t;

  vec_t tbl[9] = '{
    '{2'b01, 16'h3F80, 16'h4000, 6'b000000, 1'b1, 1'b0},
    '{2'b01, 16'hBF80, 16'hC000, 6'b000000, 1'b0, 1'b0},
    '{2'b10, 16'h4000, 16'h4000, 6'b000000, 1'b1, 1'b0},
    '{2'b00, 16'h7F81, 16'h3F80, 6'b010000, 1'b0, 1'b1},
    '{2'b00, 16'h7FC0, 16'h3F80, 6'b001000, 1'b0, 1'b0},
    '{2'b10, 16'h7FC0, 16'h3F80, 6'b001000, 1'b0, 1'b1},
    '{2'b00, 16'h0001, 16'h8000, 6'b100100, 1'b1, 1'b0},
    '{2'b00, 16'h7F80, 16'h7F80, 6'b000000, 1'b1, 1'b0},
    '{2'b01, 16'hFF80, 16'h7F80, 6'b000000, 1'b1, 1'b0}
  };

  // Behavioural comparator: result registered one cycle after a do* pulse.
  function automatic logic [1:0] cmp_ref(
      input logic eq, input logic lt, input logic le,
      input logic sa, input logic [14:0] ma, input logic nana, input logic snana,
      input logic sb_, input logic [14:0] mb, input logic nanb, input logic snanb);
    logic nan, snan, bz, eqv, ltv;
    nan  = nana | nanb;
    snan = snana | snanb;
    bz   = (ma == 15'd0) && (mb == 15'd0);
    eqv  = bz || (sa == sb_ && ma == mb);
    if (bz)             ltv = 1'b0;
    else if (sa != sb_) ltv = sa;
    else if (!sa)       ltv = ma < mb;
    else                ltv = ma > mb;
    if (eq)      return {~nan & eqv, snan};
    else if (lt) return {~nan & ltv, nan};
    else if (le) return {~nan & (ltv | eqv), nan};
    return 2'b00;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.cmp_i          <= 1'b0;
      bus.isCmpValid_i   <= 1'b0;
      bus.isCmpInvalid_i <= 1'b0;
    end else begin
      bus.isCmpValid_i <= bus.doEq_o | bus.doLt_o | bus.doLe_o;
      {bus.cmp_i, bus.isCmpInvalid_i} <= cmp_ref(bus.doEq_o, bus.doLt_o, bus.doLe_o,
          bus.opASign_o, {bus.opAExp_o, bus.opAFract_o}, bus.isASNaN_o | bus.isAQNaN_o, bus.isASNaN_o,
          bus.opBSign_o, {bus.opBExp_o, bus.opBFract_o}, bus.isBSNaN_o | bus.isBQNaN_o, bus.isBSNaN_o);
    end
  end

  always @(posedge clk) begin
    if (bus.doEq_o) n_eq++;
    if (bus.doLt_o) n_lt++;
    if (bus.doLe_o) n_le++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    n_eq = 0; n_lt = 0; n_le = 0;
  endtask

  // Starts just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic ec, input logic ei);
    int n = 0;
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_opA_i   = a;
    bus.req_opB_i   = b;
    sb.push_back({ec, ei});
    @(negedge clk);
    while (!bus.req_ready_o && n < 50) begin n++; @(negedge clk); end
    check("req_accept", bus.req_ready_o, 1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.rsp_valid_o && n < 50) begin n++; @(negedge clk); end
    check({tag, "_rsp_valid"}, bus.rsp_valid_o, 1);
  endtask

  // Compares the currently presented response with the oldest expectation.
  task automatic compare_rsp(input string tag);
    check({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      last_exp = sb.pop_front();
      check({tag, "_cmp"}, bus.rsp_cmp_o, last_exp[1]);
      check({tag, "_invalid"}, bus.rsp_invalid_o, last_exp[0]);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_do"}, {bus.doLe_o, bus.doLt_o, bus.doEq_o}, 0);
    check({tag, "_rsp"}, {bus.rsp_valid_o, bus.rsp_cmp_o, bus.rsp_invalid_o}, 0);
    check({tag, "_fields"}, {bus.opASign_o, bus.opAExp_o, bus.opAFract_o}, 0);
    check({tag, "_fieldsB"}, {bus.opBSign_o, bus.opBExp_o, bus.opBFract_o}, 0);
    check({tag, "_flags"}, {bus.isAZer_o, bus.isASNaN_o, bus.isAQNaN_o,
                            bus.isBZer_o, bus.isBSNaN_o, bus.isBQNaN_o}, 0);
  endtask

  initial begin
    logic [15:0] fa;
    bus.req_valid_i = 1'b0;
    bus.req_op_i    = 2'b00;
    bus.req_opA_i   = 16'h0000;
    bus.req_opB_i   = 16'h0000;
    bus.rsp_ready_i = 1'b1;

    // reset state
    #12;
    check_idle_outputs("reset");
    check("reset_req_ready", bus.req_ready_o, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: +0 == -0, exact pulse width and latency
    clr_cnt();
    send(2'b00, 16'h0000, 16'h8000, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_issue_doEq", bus.doEq_o, 1);
    check("t1_issue_rsp_valid", bus.rsp_valid_o, 0);
    check("t1_zero_flags", {bus.isAZer_o, bus.isBZer_o, bus.opBSign_o}, 3'b111);
    @(negedge clk);
    check("t1_wait_doEq", bus.doEq_o, 0);
    check("t1_wait_rsp_valid", bus.rsp_valid_o, 0);
    @(negedge clk);
    check("t1_lat2_rsp_valid", bus.rsp_valid_o, 1);
    compare_rsp("t1");
    check("t1_pulse_count", {n_le[3:0], n_lt[3:0], n_eq[3:0]}, 12'h001);
    @(posedge clk); #1;

    // 2-4: compare table, including NaN, denormal and infinity operands
    for (int i = 0; i < 9; i++) begin
      clr_cnt();
      send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ec, tbl[i].ei);
      fa = tbl[i].a;
      @(negedge clk);
      check($sformatf("v%0d_do_onehot", i), {bus.doLe_o, bus.doLt_o, bus.doEq_o}, 3'b001 << tbl[i].op);
      check($sformatf("v%0d_flags", i), {bus.isAZer_o, bus.isASNaN_o, bus.isAQNaN_o,
                                         bus.isBZer_o, bus.isBSNaN_o, bus.isBQNaN_o}, tbl[i].fl);
      check($sformatf("v%0d_opA", i), {bus.opASign_o, bus.opAExp_o, bus.opAFract_o},
            (fa[14:7] == 8'h00) ? {fa[15], 15'h0000} : fa);
      @(negedge clk);
      check($sformatf("v%0d_wait_do", i), {bus.doLe_o, bus.doLt_o, bus.doEq_o}, 0);
      check($sformatf("v%0d_wait_opA", i), {bus.opASign_o, bus.opAExp_o, bus.opAFract_o},
            (fa[14:7] == 8'h00) ? {fa[15], 15'h0000} : fa);
      wait_rsp($sformatf("v%0d", i));
      compare_rsp($sformatf("v%0d", i));
      check($sformatf("v%0d_pulse_count", i), n_eq + n_lt + n_le, 1);
      @(posedge clk); #1;
    end

    // 5: backpressure, then same-cycle hand-off to a new request
    bus.rsp_ready_i = 1'b0;
    clr_cnt();
    send(2'b01, 16'h3F80, 16'h4000, 1'b1, 1'b0);
    wait_rsp("t5a");
    compare_rsp("t5a");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t5_hold%0d_rsp", k), {bus.rsp_valid_o, bus.rsp_cmp_o, bus.rsp_invalid_o},
            {1'b1, last_exp});
      check($sformatf("t5_hold%0d_req_ready", k), bus.req_ready_o, 0);
    end
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = 2'b01;
    bus.req_opA_i   = 16'hBF80;
    bus.req_opB_i   = 16'hC000;
    sb.push_back(2'b00);
    @(negedge clk);
    check("t5_handoff_req_ready", bus.req_ready_o, 1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    check("t5_next_doLt", bus.doLt_o, 1);
    check("t5_next_rsp_valid", bus.rsp_valid_o, 0);
    wait_rsp("t5b");
    compare_rsp("t5b");
    check("t5_pulse_count", n_lt, 2);
    @(posedge clk); #1;

    // 6: illegal opcode answered locally after one cycle
    clr_cnt();
    send(2'b11, 16'h3F80, 16'h3F80, 1'b0, 1'b1);
    @(negedge clk);
    check("t6_ill_lat1_rsp_valid", bus.rsp_valid_o, 1);
    compare_rsp("t6_ill");
    check("t6_ill_no_pulse", n_eq + n_lt + n_le, 0);
    @(posedge clk); #1;

    // 6: reset during WAIT drops the op
    send(2'b00, 16'h3F80, 16'h3F80, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t6_wait_rsp_valid", bus.rsp_valid_o, 0);
    #1 rst = 1'b0;
    #1;
    check_idle_outputs("t6_rst");
    sb.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("t6_no_stale%0d", k), bus.rsp_valid_o, 0);
    end
    @(posedge clk); #1;

    // recovery after reset
    send(2'b10, 16'h3F80, 16'h4000, 1'b1, 1'b0);
    wait_rsp("t6_recover");
    compare_rsp("t6_recover");
    @(posedge clk); #1;
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
